alu_share_arbiter: RTL

- Shares one 4-bit ALU (add, multiply, XOR, XNOR) between two requesters, port 0 and port 1.
- Uses round-robin arbitration with a valid/ready request handshake.
- Holds one operation in flight at a time, registers the result and returns it with a valid/ready response handshake.
- Sits between the two requesting blocks and the ALU datapath, and is the only driver of that datapath.

---
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of a single 4-bit ALU (add, mul, xor, xnor).
// One operation in flight; result is registered and returned with a valid/ready handshake.
module alu_share_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid0,
    output logic             req_ready0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [1:0]       op0,
    input  logic             req_valid1,
    output logic             req_ready1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic [1:0]       op1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     result,
    output logic             flag,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done,
    output logic [1:0]       fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready* is asserted only in IDLE; resp_valid is high exactly while in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state, state_next;
    logic         prio;
    logic [W-1:0] a_q, b_q;
    logic [1:0]   op_q;
    logic         id_q;

    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [W-1:0]   alu_result;
    logic           alu_flag;

    always_comb begin
        req_ready0 = 1'b0;
        req_ready1 = 1'b0;
        if (state == IDLE) begin
            req_ready0 = req_valid0 & (~req_valid1 | ~prio);
            req_ready1 = req_valid1 & (~req_valid0 | prio);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_ready0 || req_ready1) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum        = {1'b0, a_q} + {1'b0, b_q};
        prod       = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
        alu_result = '0;
        alu_flag   = 1'b0;
        case (op_q)
            2'b00: begin
                alu_result = sum[W-1:0];
                alu_flag   = sum[W];
            end
            2'b01: begin
                alu_result = prod[W-1:0];
                alu_flag   = |prod[2*W-1:W];
            end
            2'b10:   alu_result = a_q ^ b_q;
            default: alu_result = ~(a_q ^ b_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            result   <= '0;
            flag     <= 1'b0;
            resp_id  <= 1'b0;
            ops_done <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // The winner's operands are latched; priority moves to the other port.
                    if (req_ready0 || req_ready1) begin
                        a_q  <= req_ready1 ? a1 : a0;
                        b_q  <= req_ready1 ? b1 : b0;
                        op_q <= req_ready1 ? op1 : op0;
                        id_q <= req_ready1;
                        prio <= ~req_ready1;
                    end
                end
                EXEC: begin
                    result  <= alu_result;
                    flag    <= alu_flag;
                    resp_id <= id_q;
                end
                RESP: if (resp_ready) ops_done <= ops_done + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

endmodule
